// File: rtl/dec_key_pkg.sv
// Shared key codes, FSM encoding and widths for the decimal key-entry writer.
package dec_key_pkg;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;

  localparam int         ACC_W   = 10;
  localparam logic [1:0] ADR_DIG = 2'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADR   = 3'd1,
    DAT   = 3'd2,
    WRITE = 3'd3,
    ERR   = 3'd4
  } state_t;

endpackage

// File: rtl/dec_key_writer_acc.sv
// Decimal accumulator datapath: acc*10+digit built from shifts, plus the
// address/data range checks on the full accumulator width.
module dec_acc
  import dec_key_pkg::*;
#(
  parameter int ADR_W  = 4,
  parameter int DATA_W = 8
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [3:0]       digit,
  output logic [ACC_W-1:0] acc_next,
  output logic             adr_ok,
  output logic             dat_ok
);

  localparam logic [ACC_W-1:0] ADR_MAX = ACC_W'((1 << ADR_W) - 1);
  localparam logic [ACC_W-1:0] DAT_MAX = ACC_W'((1 << DATA_W) - 1);

  // Only evaluated while acc <= 99, so the 10-bit result never overflows.
  assign acc_next = (acc << 3) + (acc << 1) + ACC_W'(digit);
  assign adr_ok   = (acc <= ADR_MAX);
  assign dat_ok   = (acc <= DAT_MAX);

endmodule

// File: rtl/dec_key_writer.sv
// Decimal keypad front end: collects an address then data bytes as decimal
// digits and issues one-cycle write strobes to the register file.
module dec_key_writer
  import dec_key_pkg::*;
#(
  parameter int ADR_W    = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_DIG  = 3,
  parameter int AUTO_INC = 1
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  output logic              wr_en,
  output logic [ADR_W-1:0]  wr_adr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ACC_W-1:0]  acc_val,
  output logic [1:0]        dig_cnt,
  output logic [2:0]        state,
  output logic              err
);

  state_t              state_reg;
  logic [ACC_W-1:0]    acc_reg;
  logic [1:0]          dig_reg;
  logic [ADR_W-1:0]    adr_reg;
  logic [DATA_W-1:0]   data_reg;
  logic                wr_en_reg;
  logic                err_reg;

  logic [ACC_W-1:0]    acc_next;
  logic                adr_ok;
  logic                dat_ok;
  logic                is_digit;
  logic                is_enter;
  logic                is_clear;

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_enter = key_valid && (key_code == KEY_ENTER);
  assign is_clear = key_valid && (key_code == KEY_CLEAR);

  dec_acc #(
    .ADR_W  (ADR_W),
    .DATA_W (DATA_W)
  ) u_acc (
    .acc      (acc_reg),
    .digit    (key_code),
    .acc_next (acc_next),
    .adr_ok   (adr_ok),
    .dat_ok   (dat_ok)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      dig_reg   <= '0;
      adr_reg   <= '0;
      data_reg  <= '0;
      wr_en_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      wr_en_reg <= 1'b0;
      // CLEAR wins over everything, including the WRITE cycle; address is kept.
      if (is_clear) begin
        state_reg <= IDLE;
        acc_reg   <= '0;
        dig_reg   <= '0;
        err_reg   <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (is_digit) begin
              state_reg <= ADR;
              acc_reg   <= ACC_W'(key_code);
              dig_reg   <= 2'd1;
            end
          end
          ADR: begin
            if (is_digit) begin
              if (dig_reg != ADR_DIG) begin
                acc_reg <= acc_next;
                dig_reg <= dig_reg + 2'd1;
              end
            end else if (is_enter) begin
              if (adr_ok) begin
                adr_reg   <= acc_reg[ADR_W-1:0];
                acc_reg   <= '0;
                dig_reg   <= '0;
                state_reg <= DAT;
              end else begin
                state_reg <= ERR;
                err_reg   <= 1'b1;
              end
            end
          end
          DAT: begin
            if (is_digit) begin
              if (dig_reg != 2'(MAX_DIG)) begin
                acc_reg <= acc_next;
                dig_reg <= dig_reg + 2'd1;
              end
            end else if (is_enter && (dig_reg != 2'd0)) begin
              if (dat_ok) begin
                data_reg  <= acc_reg[DATA_W-1:0];
                wr_en_reg <= 1'b1;
                state_reg <= WRITE;
              end else begin
                state_reg <= ERR;
                err_reg   <= 1'b1;
              end
            end
          end
          WRITE: begin
            // Strobe is high for this single cycle; keys other than CLEAR are dropped.
            state_reg <= DAT;
            acc_reg   <= '0;
            dig_reg   <= '0;
            adr_reg   <= adr_reg + ADR_W'(AUTO_INC);
          end
          ERR: begin
            err_reg <= 1'b1;
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign wr_en   = wr_en_reg;
  assign wr_adr  = adr_reg;
  assign wr_data = data_reg;
  assign acc_val = acc_reg;
  assign dig_cnt = dig_reg;
  assign state   = state_reg;
  assign err     = err_reg;

endmodule

// File: tb/tb_dec_key_writer.sv
// Directed plus randomized key sequences for dec_key_writer, checked against a
// behavioural model of the decimal-entry rules.
module tb_dec_key_writer;
  import dec_key_pkg::*;

  logic        clk = 1'b0;
  logic        clrn;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        wr_en;
  logic [3:0]  wr_adr;
  logic [7:0]  wr_data;
  logic [9:0]  acc_val;
  logic [1:0]  dig_cnt;
  logic [2:0]  state;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state (plain integers, decoded by meaning not encoding).
  logic [2:0] m_st;
  int         m_acc, m_dig, m_adr, m_data;
  int         m_wren, m_err;

  always #5 clk = ~clk;

  dec_key_writer #(
    .ADR_W    (4),
    .DATA_W   (8),
    .MAX_DIG  (3),
    .AUTO_INC (1)
  ) dut (
    .clk       (clk),
    .clrn      (clrn),
    .key_valid (key_valid),
    .key_code  (key_code),
    .wr_en     (wr_en),
    .wr_adr    (wr_adr),
    .wr_data   (wr_data),
    .acc_val   (acc_val),
    .dig_cnt   (dig_cnt),
    .state     (state),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = IDLE; m_acc = 0; m_dig = 0; m_adr = 0; m_data = 0; m_wren = 0; m_err = 0;
  endtask

  // One clock edge of the entry rules.
  task automatic model_step(input bit v, input int k);
    bit was_write;
    was_write = (m_st == WRITE);
    m_wren = 0;
    if (v && k == 11) begin
      m_st = IDLE; m_acc = 0; m_dig = 0; m_err = 0;
    end else if (was_write) begin
      m_st = DAT; m_acc = 0; m_dig = 0; m_adr = (m_adr + 1) % 16;
    end else if (m_st == IDLE) begin
      if (v && k <= 9) begin m_st = ADR; m_acc = k; m_dig = 1; end
    end else if (m_st == ADR) begin
      if (v && k <= 9) begin
        if (m_dig < 2) begin m_acc = m_acc * 10 + k; m_dig++; end
      end else if (v && k == 10) begin
        if (m_acc <= 15) begin m_adr = m_acc; m_acc = 0; m_dig = 0; m_st = DAT; end
        else begin m_st = ERR; m_err = 1; end
      end
    end else if (m_st == DAT) begin
      if (v && k <= 9) begin
        if (m_dig < 3) begin m_acc = m_acc * 10 + k; m_dig++; end
      end else if (v && k == 10 && m_dig != 0) begin
        if (m_acc <= 255) begin m_data = m_acc; m_wren = 1; m_st = WRITE; end
        else begin m_st = ERR; m_err = 1; end
      end
    end
  endtask

  task automatic check_all();
    chk("state", 32'(state), 32'(m_st));
    chk("wr_en", 32'(wr_en), 32'(m_wren));
    chk("wr_adr", 32'(wr_adr), 32'(m_adr));
    chk("wr_data", 32'(wr_data), 32'(m_data));
    chk("acc_val", 32'(acc_val), 32'(m_acc));
    chk("dig_cnt", 32'(dig_cnt), 32'(m_dig));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state), 32'(IDLE));
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_wr_adr"}, 32'(wr_adr), 0);
    chk({tag, "_wr_data"}, 32'(wr_data), 0);
    chk({tag, "_acc"}, 32'(acc_val), 0);
    chk({tag, "_dig"}, 32'(dig_cnt), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  task automatic cyc(input bit v, input int k);
    @(negedge clk);
    key_valid = v;
    key_code  = 4'(k);
    @(posedge clk);
    model_step(v, k);
    #1;
    key_valid = 1'b0;
    check_all();
    $display("cycle key_valid=%0d key=%h state=%0d wr_en=%0d adr=%0d data=%0d acc=%0d dig=%0d err=%0d",
             v, k[3:0], state, wr_en, wr_adr, wr_data, acc_val, dig_cnt, err);
  endtask

  task automatic key(input int k);
    cyc(1'b1, k);
  endtask

  task automatic idle();
    cyc(1'b0, 0);
  endtask

  initial begin
    int r;
    clrn = 1'b0; key_valid = 1'b0; key_code = 4'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    clrn = 1'b1;

    // Address 12, data 200.
    key(1); key(2); key(10);
    key(2); key(0); key(0); key(10);
    chk("t1_wr_en", 32'(wr_en), 1);
    chk("t1_adr", 32'(wr_adr), 12);
    chk("t1_data", 32'(wr_data), 200);
    idle();
    chk("t1_wr_en_drop", 32'(wr_en), 0);
    chk("t1_adr_inc", 32'(wr_adr), 13);
    chk("t1_state_dat", 32'(state), 32'(DAT));

    // Address 15 wraps to 0 after the write.
    key(11); key(1); key(5); key(10); key(7); key(10);
    chk("wrap_adr15", 32'(wr_adr), 15);
    chk("wrap_data7", 32'(wr_data), 7);
    idle();
    chk("wrap_adr0", 32'(wr_adr), 0);

    // Address 16 is out of range.
    key(11); key(1); key(6); key(10);
    chk("adr16_err", 32'(err), 1);
    key(3); key(10);
    chk("err_sticky", 32'(state), 32'(ERR));
    key(11);
    chk("clr_err", 32'(err), 0);
    chk("clr_idle", 32'(state), 32'(IDLE));
    chk("clr_adr_kept", 32'(wr_adr), 0);

    // Data 256 errors, 255 writes, fourth digit dropped.
    key(3); key(10); key(2); key(5); key(6); key(10);
    chk("d256_err", 32'(state), 32'(ERR));
    chk("d256_no_wr", 32'(wr_en), 0);
    key(11); key(3); key(10); key(2); key(5); key(5); key(9);
    chk("d4th_acc", 32'(acc_val), 255);
    chk("d4th_dig", 32'(dig_cnt), 3);
    key(10);
    chk("d255_data", 32'(wr_data), 255);
    chk("d255_wr_en", 32'(wr_en), 1);
    key(4);
    chk("wr_drop_acc", 32'(acc_val), 0);
    chk("wr_drop_state", 32'(state), 32'(DAT));
    key(10);
    chk("empty_enter", 32'(wr_en), 0);

    // Reset asserted during the WRITE cycle.
    key(7); key(10);
    chk("mid_wr_en", 32'(wr_en), 1);
    clrn = 1'b0;
    #1;
    check_reset_vals("midwr");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    clrn = 1'b1;

    // Random keys against the model.
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 25)      idle();
      else if (r < 75) key(int'($urandom_range(0, 9)));
      else if (r < 88) key(10);
      else if (r < 93) key(11);
      else             key(int'($urandom_range(12, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
